// File: rtl/key_pulse.sv
// key_pulse: button front-end for the mode/confirm keys.
//
// Each raw button is synchronised (2 flops), debounced with its own counter and rise-detected.
// A rise sets a per-button pending bit; a fixed-priority arbiter (up > left > right > confirm)
// drains one pending bit per cycle onto a registered single-cycle pulse, so at most one
// command pulse is ever high.
//
// Optional feature: define KEY_REPEAT_EN to build auto-repeat on left/right. Without it the
// REPEAT_* parameters are only range-checked.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   btn_*_i              raw asynchronous buttons, active-high
//   up_o .. confirm_o    one-cycle command pulses, mutually exclusive
//   key_level_o          debounced levels {up, left, right, confirm}
module key_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned REP_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_confirm_i,
  output logic       up_o,
  output logic       left_o,
  output logic       right_o,
  output logic       confirm_o,
  output logic [3:0] key_level_o
);

  // Elaboration-time parameter sanity check.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      (64'd1 << REP_W) <= 64'(REPEAT_DELAY) ||
      (64'd1 << REP_W) <= 64'(REPEAT_PERIOD)) begin : g_bad_params
    $error("key_pulse: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: [3]=up, [2]=left, [1]=right, [0]=confirm.
  logic [3:0] raw;
  logic [3:0] sync_a, sync_b;
  logic [3:0] stable_q, stable_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] pulse_q;
  logic [3:0] press;
  logic [3:0] rep_evt;
  logic [3:0] grant;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign raw = {btn_up_i, btn_left_i, btn_right_i, btn_confirm_i};

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync_b[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync_b[i];
          press[i]    = sync_b[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [REP_W-1:0] RepDelayLast  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RepPeriodLast = REP_W'(REPEAT_PERIOD - 1);

  // Index 0 serves right (bit 1), index 1 serves left (bit 2).
  logic [REP_W-1:0] rep_cnt_q [2];
  logic [REP_W-1:0] rep_cnt_d [2];
  logic [1:0]       rep_run_q, rep_run_d;

  // Counter runs only while the key is held and stays held; the press edge itself and the
  // falling edge both leave it cleared, so the first repeat lands REPEAT_DELAY after the press.
  always_comb begin
    rep_evt = '0;
    for (int j = 0; j < 2; j++) begin
      rep_cnt_d[j] = '0;
      rep_run_d[j] = 1'b0;
      if (stable_q[j+1] && stable_d[j+1]) begin
        rep_run_d[j] = rep_run_q[j];
        rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
        if ((!rep_run_q[j] && rep_cnt_q[j] == RepDelayLast) ||
            (rep_run_q[j] && rep_cnt_q[j] == RepPeriodLast)) begin
          rep_evt[j+1] = 1'b1;
          rep_cnt_d[j] = '0;
          rep_run_d[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_run_q <= '0;
      for (int j = 0; j < 2; j++) rep_cnt_q[j] <= '0;
    end else begin
      rep_run_q <= rep_run_d;
      for (int j = 0; j < 2; j++) rep_cnt_q[j] <= rep_cnt_d[j];
    end
  end
`else
  assign rep_evt = '0;
`endif

  // Fixed-priority grant; a new event on the granted bit in the same cycle re-arms it.
  always_comb begin
    grant = '0;
    if (pending_q[3])      grant = 4'b1000;
    else if (pending_q[2]) grant = 4'b0100;
    else if (pending_q[1]) grant = 4'b0010;
    else if (pending_q[0]) grant = 4'b0001;
    pending_d = (pending_q & ~grant) | press | rep_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync_a    <= raw;
      sync_b    <= sync_a;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      pulse_q   <= grant;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign up_o        = pulse_q[3];
  assign left_o      = pulse_q[2];
  assign right_o     = pulse_q[1];
  assign confirm_o   = pulse_q[0];
  assign key_level_o = stable_q;

endmodule

// File: tb/tb_key_pulse.sv
// Self-checking bench for key_pulse: directed scenarios plus random button activity,
// checked by a scoreboard fed from a window-based reference model.
module tb_key_pulse;

  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;  // {up, left, right, confirm}
  logic       up_o, left_o, right_o, confirm_o;
  logic [3:0] key_level;

  key_pulse #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REP_W          (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up_i     (btn[3]),
    .btn_left_i   (btn[2]),
    .btn_right_i  (btn[1]),
    .btn_confirm_i(btn[0]),
    .up_o         (up_o),
    .left_o       (left_o),
    .right_o      (right_o),
    .confirm_o    (confirm_o),
    .key_level_o  (key_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int idx;
  } exp_t;
  exp_t expq[$];

  int       cyc = 0;      // number of rising edges seen
  bit [3:0] r1, r2;       // raw samples from one and two edges ago
  bit [3:0] hist[$];      // last DC synchronised samples seen at edges
  bit [3:0] m_stable, m_pend, m_ns, m_press, m_rep;
  bit       m_all;
  int       m_g;
  int       tp[4];        // edge at which each key's level last rose

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      r1 = '0; r2 = '0; m_stable = '0; m_pend = '0;
      hist.delete();
    end else begin
      hist.push_back(r2);
      if (hist.size() > DC) void'(hist.pop_front());
      // Level flips once the last DC synchronised samples all disagree with it.
      m_ns = m_stable;
      for (int i = 0; i < 4; i++) begin
        if (hist.size() == DC) begin
          m_all = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) m_all = 1'b0;
          if (m_all) m_ns[i] = ~m_stable[i];
        end
      end
      m_press = m_ns & ~m_stable;
      m_rep   = '0;
`ifdef KEY_REPEAT_EN
      for (int i = 1; i <= 2; i++) begin
        if (m_stable[i] && m_ns[i] && cyc >= tp[i] + RD && ((cyc - tp[i] - RD) % RP) == 0)
          m_rep[i] = 1'b1;
      end
`endif
      for (int i = 0; i < 4; i++) if (m_press[i]) tp[i] = cyc;
      m_g = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_g < 0) m_g = i;
      if (m_g >= 0) expq.push_back('{cyc: cyc, idx: m_g});
      if (m_g >= 0) m_pend[m_g] = 1'b0;
      m_pend   = m_pend | m_press | m_rep;
      m_stable = m_ns;
      r2 = r1;
      r1 = btn;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   pcnt[4];
  int   first[4];
  logic [3:0] outs;
  exp_t e;
  int   pidx;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      outs = {up_o, left_o, right_o, confirm_o};
      if (rst) begin
        check("reset_outputs", int'({outs, key_level}), 0);
      end else begin
        check("key_level", int'(key_level), int'(m_stable));
        check("one_hot", int'($countones(outs) <= 1), 1);
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          e = expq.pop_front();
          check("missed_pulse_key", -1, e.idx);
        end
        if (outs != 0) begin
          pidx = 0;
          for (int i = 0; i < 4; i++) if (outs[i]) pidx = i;
          if (pcnt[pidx] == 0) first[pidx] = cyc;
          pcnt[pidx]++;
          if (expq.size() == 0) begin
            check("unexpected_pulse_key", pidx, -1);
          end else begin
            e = expq.pop_front();
            check("pulse_key", pidx, e.idx);
            check("pulse_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int e0;

  function automatic int exp_count(int hold, bit rep_key);
    int n = 1;
`ifdef KEY_REPEAT_EN
    if (rep_key && hold > RD) n += (hold - RD - 1) / RP + 1;
`endif
    return n;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      pcnt[i]  = 0;
      first[i] = 0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_hold(logic [3:0] mask, int hold);
    @(negedge clk);
    clear_counts();
    btn = mask;
    e0  = cyc + 1;
    idle(hold);
    btn = '0;
    idle(14);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(4);

    // Clean left press held 50 cycles.
    press_hold(4'b0100, 50);
    check("s1_left_first", first[2] - e0, DC + 2);
    check("s1_left_count", pcnt[2], exp_count(50, 1'b1));

    // Right bounces, then is held.
    @(negedge clk);
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      btn[1] = ~k[0];
      idle(2);
    end
    btn[1] = 1'b1;
    e0 = cyc + 1;
    idle(20);
    btn = '0;
    idle(14);
    check("s2_right_count", pcnt[1], 1);
    check("s2_right_first", first[1] - e0, DC + 2);

    // Simultaneous up/left/confirm serialise in priority order.
    press_hold(4'b1101, 10);
    check("s3_up_first", first[3] - e0, DC + 2);
    check("s3_left_first", first[2] - e0, DC + 3);
    check("s3_confirm_first", first[0] - e0, DC + 4);

    // Reset in the middle of a confirm debounce, confirm kept held.
    @(negedge clk);
    btn = 4'b0001;
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clear_counts();
    e0 = cyc + 1;
    idle(15);
    btn = '0;
    idle(14);
    check("s4_confirm_count", pcnt[0], 1);
    check("s4_confirm_first", first[0] - e0, DC + 2);

    // Long right hold: repeats only with the feature enabled.
    press_hold(4'b0010, 60);
    check("s5_right_count", pcnt[1], exp_count(60, 1'b1));

    // Long up hold never repeats.
    press_hold(4'b1000, 100);
    check("s6_up_count", pcnt[3], 1);

    // Random activity with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    btn = '0;
    idle(20);
    check("scoreboard_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_pulse.md
# key_pulse

Front-end conditioner for the four mode/confirm push-buttons. Synchronises, debounces and edge-detects the raw board inputs, then issues single-cycle, mutually exclusive command pulses (`up_o`, `left_o`, `right_o`, `confirm_o`). These pulses feed the mode/state shifter directly downstream. That stage decodes `{up, left, right}` as one-hot and ignores combinations, so this block must never assert two pulses in the same cycle.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000 — consecutive cycles a synchronised input must differ from its stable level before the level flips (10 ms at 100 MHz); must be ≥1.
- `CNT_W`, 20 — debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `REPEAT_DELAY`, 50_000_000 — hold time before auto-repeat starts (used only with `KEY_REPEAT_EN`).
- `REPEAT_PERIOD`, 10_000_000 — auto-repeat interval (used only with `KEY_REPEAT_EN`).
- `REP_W`, 26 — repeat counter width; must satisfy 2^REP_W > max(REPEAT_DELAY, REPEAT_PERIOD).
- `clk` in 1 — system clock; all logic on rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `btn_up_i` in 1 — raw up button, active-high, asynchronous to `clk`.
- `btn_left_i` in 1 — raw left button.
- `btn_right_i` in 1 — raw right button.
- `btn_confirm_i` in 1 — raw confirm button.
- `up_o` out 1 — one-cycle pulse per accepted up press.
- `left_o` out 1 — one-cycle pulse per accepted left press or repeat.
- `right_o` out 1 — one-cycle pulse per accepted right press or repeat.
- `confirm_o` out 1 — one-cycle pulse per accepted confirm press.
- `key_level_o` out 4 — debounced stable levels, bit order `{up, left, right, confirm}`.

## Operation
- **Reset.** Asserting `rst` clears all outputs, synchroniser flops, stable levels, counters and pending bits to 0, immediately and asynchronously. A button held through reset is seen as a new press after reset release.
- **Synchroniser.** Each button passes through two flops. Call the second flop's output `sync`.
- **Debounce.** Each button has its own counter.
  - If `sync == stable`, the counter loads 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, then `stable <= sync` and the counter loads 0.
  - Otherwise the counter increments.
  - Any bounce back to the stable level restarts the count from 0.
- **Edge detect.** The clock edge on which `stable` goes 0→1 also sets that button's `pending` bit. The 1→0 transition produces nothing.
  - If `pending` is already set, the new event merges into it; there is no double count.
- **Arbiter.** Every cycle, the highest-priority set pending bit is registered onto its output and cleared on the same edge.
  - Priority order: up > left > right > confirm.
  - Exactly zero or one output is high in any cycle.
  - Simultaneous presses are serialised into consecutive cycles in priority order.
  - A pending bit that loses arbitration stays set until granted.
- **Outputs.** All outputs are registered. Each pulse lasts exactly 1 cycle. `key_level_o` equals the `stable` vector.

## Timing
- Let E0 be the first edge that samples a raw input at 1, with the input held.
  - `sync` = 1 after E1.
  - `stable` and `pending` set at E(1+DEBOUNCE_CYCLES).
  - Output pulse is high after E(2+DEBOUNCE_CYCLES) for one cycle, provided no higher-priority pending bit exists.
- Each higher-priority pending bit ahead of a button delays its pulse by one cycle.
- **Release.** `key_level_o` bit drops DEBOUNCE_CYCLES+2 edges after the raw input falls; no pulse is generated.
- **Throughput.** Up to one pulse per cycle across all buttons; each button can produce at most one press per debounce window.
- **Reset mid-debounce or with pending bits set.** All progress is discarded; no pulse is emitted after reset release unless a fresh debounce completes.

## Configuration
- **`KEY_REPEAT_EN` defined.** Left and right auto-repeat; up and confirm never repeat.
  - While left or right `stable` is 1, its repeat counter runs.
  - REPEAT_DELAY cycles after the press edge, its `pending` bit is set again.
  - After that, `pending` is set again every REPEAT_PERIOD cycles.
  - The repeat counter clears when `stable` falls.
  - Repeat events obey the same arbitration and merge rules as presses.
- **`KEY_REPEAT_EN` undefined.** No repeat logic is built. Exactly one pulse per debounced press. The REPEAT_* parameters are accepted but unused.

## Test plan
Run with DEBOUNCE_CYCLES=4; REPEAT_DELAY=20 and REPEAT_PERIOD=8 where repeat applies.
- Raw left rises clean at E0 and is held 50 cycles → `left_o` high only in the cycle after E6; `key_level_o`=4'b0100 from E5.
- Raw right toggles 1,0,1,0 every 2 cycles, then held high → no pulse during the bounce; a single `right_o` pulse 6 edges after the final rise.
- Up, left and confirm pressed on the same edge → `up_o`, `left_o`, `confirm_o` in three consecutive cycles, never two high together.
- Assert `rst` 3 cycles into a confirm debounce, release, keep confirm held → all outputs 0 during reset; `confirm_o` pulses once, 6 edges after the first post-reset sample.
- Hold right for 60 cycles → with `KEY_REPEAT_EN`: pulses at press, +20, +28, +36, …; without it: exactly one pulse.
- Hold up for 100 cycles under `KEY_REPEAT_EN` → exactly one `up_o` pulse.
